sram_port_arbiter: RTL
======================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one SRAM-like memory port between the fetch side (inst_*) and the EXE/MEM data side (data_*).
//  Sits between the pipeline stages and the external memory port.
//  Arbitrates address phases: data side has priority, with an anti-starvation override.
//  Records the source of each accepted request in an in-order FIFO and routes data_ok/rdata back to it.
// PARAMETERS
//  MAX_OUTST   2   max accepted-but-unanswered requests (ordering FIFO depth, >=1)
//  STARVE_LIM  4   consecutive data grants while inst pending before inst is forced to win once
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high
//  inst_req       in   1   fetch request valid
//  inst_wr        in   1   fetch write flag
//  inst_size      in   2   fetch size
//  inst_addr      in   32  fetch address
//  inst_wdata     in   32  fetch write data
//  inst_addr_ok   out  1   fetch address phase accepted
//  inst_data_ok   out  1   fetch response valid
//  inst_rdata     out  32  fetch read data
//  data_req/data_wr/data_size/data_addr/data_wdata   in   1/1/2/32/32   data-side request, same meaning
//  data_addr_ok/data_data_ok/data_rdata             out  1/1/32        data-side handshake, same meaning
//  mem_req/mem_wr/mem_size/mem_addr/mem_wdata       out  1/1/2/32/32   shared port request
//  mem_addr_ok    in   1   memory accepted address phase
//  mem_data_ok    in   1   memory response valid, in request order
//  mem_rdata      in   32  memory read data
//  err_rsp        out  1   sticky: mem_data_ok seen with FIFO empty
// BEHAVIOUR
//  Reset:
//   - mem_req=0, all *_addr_ok/*_data_ok=0, err_rsp=0.
//   - FIFO empty, grant lock clear, starve counter 0.
//   - Reset mid-transaction discards outstanding IDs; memory is reset in the same cycle.
//  Handshakes (SRAM-like):
//   - Address phase completes on req&&addr_ok.
//   - Response completes on data_ok, one cycle minimum after the address phase.
//  Grant (combinational, from registered state):
//   - lock set: the locked source keeps the grant.
//   - else data_req && !(inst_req && starve==STARVE_LIM): data wins.
//   - else if inst_req: inst wins.
//  Request path:
//   - mem_* = mux(grant) of winner's req/wr/size/addr/wdata.
//   - mem_req=0 when FIFO full (count==MAX_OUTST) or no requester.
//  Lock:
//   - set when mem_req && !mem_addr_ok; holds the winner until mem_addr_ok.
//   - requesters keep req and payload stable until addr_ok.
//  Address ack:
//   - inst_addr_ok = mem_req && grant==INST && mem_addr_ok; data_addr_ok likewise.
//   - these are combinational pass-throughs, 0-cycle latency.
//  Push: on mem_req && mem_addr_ok, push source ID (0=inst, 1=data).
//  Pop: on mem_data_ok with count!=0, pop head.
//   - inst_data_ok = mem_data_ok && head==0; data_data_ok = mem_data_ok && head==1.
//   - rdata broadcast to both *_rdata.
//  Push and pop in the same cycle: count unchanged, FIFO pointers both advance.
//   - When full, a same-cycle pop does not enable push (full is checked on registered count).
//  Pointers wrap modulo MAX_OUTST; count is $clog2(MAX_OUTST+1) bits.
//  Unexpected response: mem_data_ok with count==0 -> no data_ok asserted, err_rsp<=1 until reset.
//  Starve counter:
//   - +1 (saturating at STARVE_LIM) on each data address-phase completion while inst_req=1.
//   - cleared on inst address-phase completion or when inst_req=0.
//  Overall latency: arbiter adds 0 cycles on both request and response paths.
// TESTING
//  T1:
//   - stimulus: inst read 0xBFC00000 alone; mem_addr_ok=1, mem_data_ok next cycle with rdata=0x3C1D0001.
//   - required: inst_addr_ok same cycle; inst_data_ok=1, inst_rdata=0x3C1D0001 next cycle; data_data_ok=0.
//  T2:
//   - stimulus: inst and data both request in cycle 0, addr_ok=1.
//   - required: data granted cycle 0 (mem_addr=data_addr); inst granted cycle 1; responses route data then inst.
//  T3:
//   - stimulus: data request with mem_addr_ok=0 for 3 cycles while inst also requests.
//   - required: mem_addr stays the data address all 3 cycles; inst_addr_ok=0 throughout.
//  T4:
//   - stimulus: data_req held high for 5 accepted requests with inst_req=1 and STARVE_LIM=4.
//   - required: 5th grant goes to inst; starve counter returns to 0.
//  T5:
//   - stimulus: MAX_OUTST=2, two accepted requests with no data_ok yet.
//   - required: mem_req=0 while full.
//   - stimulus: mem_data_ok arrives.
//   - required: head source gets data_ok; mem_req reasserts next cycle.
//  T6:
//   - stimulus: mem_data_ok with FIFO empty.
//   - required: no *_data_ok asserted; err_rsp=1 until reset.
//   - stimulus: reset with 2 requests outstanding.
//   - required: count=0, mem_req=0 the following cycle.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// SRAM-like bus: address phase on req && addr_ok, response on data_ok.
// The master drives the request payload; the slave answers with the handshake and read data.
interface sram_port_arbiter_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like memory port between the fetch side (inst_if) and the
// data side (data_if). Data wins by default; after STARVE_LIM data grants in a
// row while fetch waits, fetch wins once. An in-order FIFO of source IDs routes
// each memory response back to whoever issued the matching request.
//
// Handshake: a request is held (req + payload stable) until req && addr_ok in
// the same cycle; a response is a single data_ok pulse, in request order, at
// least one cycle after its address phase.
module sram_port_arbiter #(
   parameter  int MAX_OUTST  = 2,
   parameter  int STARVE_LIM = 4,
   localparam int CW         = $clog2(MAX_OUTST + 1),
   localparam int SW         = $clog2(STARVE_LIM + 1)
) (
   input  logic                        clk,
   input  logic                        reset,
   sram_port_arbiter_if.slave          inst_if,
   sram_port_arbiter_if.slave          data_if,
   sram_port_arbiter_if.master         mem_if,
   output logic                        err_rsp,
   output logic [1:0]                  o_dbg_state,
   output logic [CW-1:0]               o_dbg_count,
   output logic [SW-1:0]               o_dbg_starve
);

   localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

   // Grant lock: once a winner is presented without addr_ok it keeps the port.
   typedef enum logic [1:0] {
      ST_OPEN      = 2'd0,
      ST_LOCK_INST = 2'd1,
      ST_LOCK_DATA = 2'd2
   } lock_state_t;

   lock_state_t           r_state;
   lock_state_t           w_state_nxt;

   logic [MAX_OUTST-1:0]  r_fifo;      // source ID per slot: 0=inst, 1=data
   logic [PW-1:0]         r_wptr;
   logic [PW-1:0]         r_rptr;
   logic [CW-1:0]         r_count;
   logic [SW-1:0]         r_starve;
   logic                  r_err;

   logic                  w_grant_data;
   logic                  w_src_req;
   logic                  w_full;
   logic                  w_starved;
   logic                  w_mem_req;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_head;
   logic                  w_inst_acc;
   logic                  w_data_acc;
   logic [PW-1:0]         w_wptr_nxt;
   logic [PW-1:0]         w_rptr_nxt;

   assign w_full    = (r_count == CW'(MAX_OUTST));
   assign w_starved = (r_starve == SW'(STARVE_LIM));

   // Lock state register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_OPEN;
      else       r_state <= w_state_nxt;
   end

   // Grant selection, request gating and lock next-state.
   always_comb begin
      w_grant_data = 1'b0;
      w_src_req    = 1'b0;
      w_mem_req    = 1'b0;
      w_state_nxt  = r_state;
      case (r_state)
         ST_LOCK_INST: w_grant_data = 1'b0;
         ST_LOCK_DATA: w_grant_data = 1'b1;
         default:      w_grant_data = data_if.req && !(inst_if.req && w_starved);
      endcase
      w_src_req = w_grant_data ? data_if.req : inst_if.req;
      // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
      w_mem_req = w_src_req && !w_full && !reset;
      if (w_mem_req && !mem_if.addr_ok)
         w_state_nxt = w_grant_data ? ST_LOCK_DATA : ST_LOCK_INST;
      else if (w_mem_req || !w_src_req)
         w_state_nxt = ST_OPEN;
   end

   // Shared port request path: a plain mux of the winner's payload.
   assign mem_if.req   = w_mem_req;
   assign mem_if.wr    = w_grant_data ? data_if.wr    : inst_if.wr;
   assign mem_if.size  = w_grant_data ? data_if.size  : inst_if.size;
   assign mem_if.addr  = w_grant_data ? data_if.addr  : inst_if.addr;
   assign mem_if.wdata = w_grant_data ? data_if.wdata : inst_if.wdata;

   // Address acknowledges pass straight through from the memory.
   assign w_push       = w_mem_req && mem_if.addr_ok;
   assign w_inst_acc   = w_push && !w_grant_data;
   assign w_data_acc   = w_push &&  w_grant_data;
   assign inst_if.addr_ok = w_inst_acc;
   assign data_if.addr_ok = w_data_acc;

   // Response routing from the FIFO head; a response with nothing outstanding is dropped.
   assign w_pop        = mem_if.data_ok && (r_count != '0) && !reset;
   assign w_head       = r_fifo[r_rptr];
   assign inst_if.data_ok = w_pop && !w_head;
   assign data_if.data_ok = w_pop &&  w_head;
   assign inst_if.rdata   = mem_if.rdata;
   assign data_if.rdata   = mem_if.rdata;

   assign w_wptr_nxt = (r_wptr == PW'(MAX_OUTST - 1)) ? '0 : r_wptr + 1'b1;
   assign w_rptr_nxt = (r_rptr == PW'(MAX_OUTST - 1)) ? '0 : r_rptr + 1'b1;

   // Ordering FIFO: pointers advance independently, count tracks occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fifo  <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_fifo[r_wptr] <= w_grant_data;
            r_wptr         <= w_wptr_nxt;
         end
         if (w_pop) r_rptr <= w_rptr_nxt;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Starvation counter: counts data wins while fetch waits, saturating at the limit.
   always_ff @(posedge clk) begin
      if (reset)                           r_starve <= '0;
      else if (!inst_if.req || w_inst_acc) r_starve <= '0;
      else if (w_data_acc && !w_starved)   r_starve <= r_starve + SW'(1);
   end

   // Sticky flag for a memory response that matches no outstanding request.
   always_ff @(posedge clk) begin
      if (reset)                                       r_err <= 1'b0;
      else if (mem_if.data_ok && (r_count == '0))      r_err <= 1'b1;
   end

   assign err_rsp      = r_err;
   assign o_dbg_state  = r_state;
   assign o_dbg_count  = r_count;
   assign o_dbg_starve = r_starve;

endmodule
